// File: rtl/fpow_seq.sv
// fpow_seq: sequential integer power y = b^e mod 2^WIDTH.
// LSB-first square-and-multiply, one exponent bit per cycle.
module fpow_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] exp_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   base_q;
  logic [WIDTH-1:0]   e_q;
  logic [WIDTH-1:0]   y_q;
  logic               res_ovf_q;
  logic               base_ovf_q;
  logic               ovf_q;

  logic [2*WIDTH-1:0] mul_p;
  logic [2*WIDTH-1:0] sq_p;
  logic [WIDTH-1:0]   res_n;
  logic               res_ovf_n;
  logic               last;
  logic               exp_zero;

  assign mul_p = {{WIDTH{1'b0}}, res_q} * {{WIDTH{1'b0}}, base_q};
  assign sq_p  = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};

  // final RUN cycle is the one holding the top set exponent bit
  assign last     = ((e_q >> 1) == '0);
  assign exp_zero = (exp_i == '0);

  // base_ovf only matters once a multiply actually consumes that base
  always_comb begin
    res_n     = res_q;
    res_ovf_n = res_ovf_q;
    if (e_q[0]) begin
      res_n     = mul_p[WIDTH-1:0];
      res_ovf_n = res_ovf_q
                | (|mul_p[2*WIDTH-1:WIDTH])
                | base_ovf_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = exp_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      res_q      <= '0;
      base_q     <= '0;
      e_q        <= '0;
      res_ovf_q  <= 1'b0;
      base_ovf_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            res_q      <= {{(WIDTH-1){1'b0}}, 1'b1};
            base_q     <= base_i;
            e_q        <= exp_i;
            res_ovf_q  <= 1'b0;
            base_ovf_q <= 1'b0;
            if (exp_zero) begin
              y_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
              ovf_q <= 1'b0;
            end
          end
        end
        RUN: begin
          res_q      <= res_n;
          res_ovf_q  <= res_ovf_n;
          base_q     <= sq_p[WIDTH-1:0];
          base_ovf_q <= base_ovf_q | (|sq_p[2*WIDTH-1:WIDTH]);
          e_q        <= e_q >> 1;
          if (last) begin
            y_q   <= res_n;
            ovf_q <= res_ovf_n;
          end
        end
        default: ;
      endcase
    end
  end

  // result registers hold their value outside DONE
  assign y_o        = y_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fpow_seq.sv
// tb_fpow_seq: directed and model-checked bench for fpow_seq.
// All comparisons go through check().
module tb_fpow_seq;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] base_i;
  logic [7:0] exp_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] y_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  int qb[$];
  int qe[$];

  always #5 clk_i = ~clk_i;

  fpow_seq #(.WIDTH(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .base_i     (base_i),
    .exp_i      (exp_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .y_o        (y_o),
    .overflow_o (overflow_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // repeated multiplication with a saturating true value
  function automatic void model(input int b, input int e,
                                output int y, output int ov);
    int r;
    int t;
    r  = 1;
    t  = 1;
    ov = 0;
    for (int i = 0; i < e; i++) begin
      r = (r * b) & 255;
      t = t * b;
      if (t >= 256) begin
        ov = 1;
        t  = 256;
      end
    end
    y = r;
  endfunction

  task automatic do_op(input string tag, input int b, input int e,
                       input int ey, input int eo, input int elat,
                       input bit bp);
    int lat;
    @(negedge clk_i);
    check({tag, "_rdy_in"}, ready_o, 1);
    base_i  = b[7:0];
    exp_i   = e[7:0];
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_y"}, y_o, ey);
    check({tag, "_ovf"}, overflow_o, eo);
    if (bp) begin
      for (int i = 0; i < 5; i++) begin
        valid_i = i[0];
        base_i  = 8'(i * 37);
        exp_i   = 8'(i + 1);
        @(negedge clk_i);
        check({tag, "_bp_y"}, y_o, ey);
        check({tag, "_bp_ovf"}, overflow_o, eo);
        check({tag, "_bp_vld"}, valid_o, 1);
        check({tag, "_bp_rdy"}, ready_o, 0);
      end
      valid_i = 1'b0;
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check({tag, "_rdy_out"}, ready_o, 1);
    check({tag, "_vld_out"}, valid_o, 0);
  endtask

  task automatic stream(input int n);
    int issued;
    int got;
    int cyc;
    int ey;
    int eo;
    issued  = 0;
    got     = 0;
    cyc     = 0;
    ready_i = 1'b1;
    while (got < n && cyc < 20 * n + 50) begin
      @(negedge clk_i);
      cyc++;
      if (valid_o) begin
        model(qb[got], qe[got], ey, eo);
        check("str_y", y_o, ey);
        check("str_ovf", overflow_o, eo);
        got++;
      end
      if (ready_o) begin
        if (issued < n) begin
          base_i  = qb[issued][7:0];
          exp_i   = qe[issued][7:0];
          valid_i = 1'b1;
          issued++;
        end else begin
          valid_i = 1'b0;
        end
      end
    end
    check("str_count", got, n);
    valid_i = 1'b0;
    @(negedge clk_i);
    ready_i = 1'b0;
    qb.delete();
    qe.delete();
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    base_i  = '0;
    exp_i   = '0;
    repeat (2) @(negedge clk_i);
    check("rst_rdy", ready_o, 1);
    check("rst_vld", valid_o, 0);
    check("rst_y", y_o, 0);
    check("rst_ovf", overflow_o, 0);
    reset_i = 1'b0;

    do_op("p3_4", 3, 4, 81, 0, 4, 1'b0);
    do_op("p2_7", 2, 7, 128, 0, 4, 1'b0);
    do_op("p2_8", 2, 8, 0, 1, 5, 1'b0);
    do_op("p3_5", 3, 5, 243, 0, 4, 1'b0);
    do_op("p3_6", 3, 6, 217, 1, 4, 1'b0);
    do_op("p0_0", 0, 0, 1, 0, 1, 1'b0);
    do_op("p0_9", 0, 9, 0, 0, 5, 1'b0);
    do_op("p1_255", 1, 255, 1, 0, 9, 1'b0);
    do_op("p255_1", 255, 1, 255, 0, 2, 1'b0);
    do_op("p16_2", 16, 2, 0, 1, 3, 1'b0);
    do_op("bp", 3, 4, 81, 0, 4, 1'b1);

    // abort b=3 e=200 in the middle of RUN
    @(negedge clk_i);
    base_i  = 8'd3;
    exp_i   = 8'd200;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("abort_rdy", ready_o, 1);
    check("abort_vld", valid_o, 0);
    check("abort_y", y_o, 0);
    check("abort_ovf", overflow_o, 0);
    repeat (12) begin
      @(negedge clk_i);
      check("abort_quiet", valid_o, 0);
    end
    do_op("p5_3", 5, 3, 125, 0, 3, 1'b0);

    qb = '{7, 2, 0};
    qe = '{2, 9, 0};
    stream(3);

    for (int i = 0; i < 1000; i++) begin
      if (i % 3 == 0) begin
        qb.push_back($urandom_range(0, 255));
        qe.push_back($urandom_range(0, 255));
      end else begin
        qb.push_back($urandom_range(0, 6));
        qe.push_back($urandom_range(0, 12));
      end
    end
    stream(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
